// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and the blocks that sit downstream of it
// (arbiter, demux).
// Contents:
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH  default geometry: 64 entries of 8 bits
//   DEF_AF_THRESH / DEF_AE_THRESH    default almost-full / almost-empty levels
//   count_width(depth)               bits needed to hold an occupancy of 0..depth
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_AF_THRESH  = 60;
    localparam int DEF_AE_THRESH  = 4;

    // The +1 bit is needed because a full FIFO holds exactly 'depth' entries.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port memory: DEPTH x DATA_WIDTH, one write port and one read port
// with a registered output.
// Ports:
//   clk      clock; all activity on posedge
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data only updates when this is high
//   rd_addr  read address
//   rd_data  registered read data
// A read and a write to the same address in one cycle returns the old contents
// (read-before-write). The array and the output register have no reset, so the
// memory maps onto block RAM.
module fifo_ram_dp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Both assignments are non-blocking, so a colliding read samples the
    // entry before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_mem_param.sv
// Synchronous FIFO built on fifo_ram_dp. It manages its own pointers, occupancy
// count, status flags and sticky error flags.
// Ports:
//   clk           clock; all logic on posedge
//   reset         asynchronous, active-high; clears all state except the memory
//   wr_en         write request
//   rd_en         read request
//   err_clr       synchronous clear of overflow/underflow
//   data_in       write data
//   data_out      read data, one cycle after an accepted read; holds otherwise
//   data_valid    data_out holds the entry popped on the previous cycle
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   fifo_count    occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
module fifo_mem_param
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = count_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  data_valid_reg;
    logic                  has_data_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    logic wr_acc;
    logic rd_acc;

    // A full FIFO can still take a write when a read frees a slot in the same
    // cycle. An empty FIFO never forwards a same-cycle write to the read side.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            data_valid_reg <= 1'b0;
            has_data_reg   <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            data_valid_reg <= rd_acc;
            has_data_reg   <= has_data_reg | rd_acc;
            // Pointers wrap naturally at DEPTH.
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            overflow_reg  <= (overflow_reg  & ~err_clr) | (wr_en & ~wr_acc);
            underflow_reg <= (underflow_reg & ~err_clr) | (rd_en & ~rd_acc);
        end
    end

    fifo_ram_dp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_rd_data)
    );

    // The RAM output register has no reset. It is gated to zero until the
    // first read after reset, so data_out reads 0 right away when reset is
    // asserted and still holds its last value between reads.
    assign data_out     = has_data_reg ? ram_rd_data : '0;
    assign data_valid   = data_valid_reg;

    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign fifo_count   = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_mem_param.sv
module tb_fifo_mem_param;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] fifo_count;
    logic       overflow;
    logic       underflow;

    fifo_mem_param dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a queue, plus the expected error
    // flags and the last value popped.
    logic [7:0] model_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] last_dout = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovf   = 1'b0;
    logic       exp_udf   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge and advance the model by the
    // rules for accepted/rejected operations.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        logic rd_ok;
        logic wr_ok;
        int   n;
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        data_in = d;
        n     = model_q.size();
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < DEPTH) || rd_ok);
        if (rd_ok) begin
            last_dout = model_q.pop_front();
            sb_q.push_back(last_dout);
        end
        if (wr_ok) model_q.push_back(d);
        exp_ovf   = (exp_ovf && !c) || (w && !wr_ok);
        exp_udf   = (exp_udf && !c) || (r && !rd_ok);
        exp_valid = rd_ok;
        $display("txn wr=%0b rd=%0b clr=%0b din=%02h -> wr_acc=%0b rd_acc=%0b count=%0d",
                 w, r, c, d, wr_ok, rd_ok, model_q.size());
    endtask

    // Monitor: compares DUT outputs against the model shortly after each edge.
    initial begin
        logic [7:0] exp_d;
        int n;
        forever begin
            @(posedge clk);
            #2;
            n = model_q.size();
            chk("fifo_count", 32'(fifo_count), 32'(n));
            chk("full", 32'(full), 32'(n == DEPTH));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("almost_full", 32'(almost_full), 32'(n >= 60));
            chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("underflow", 32'(underflow), 32'(exp_udf));
            chk("data_valid", 32'(data_valid), 32'(exp_valid));
            if (data_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_unexpected: got %02h expected no output", data_out);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(exp_d));
                end
            end else begin
                chk("data_hold", 32'(data_out), 32'(last_dout));
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: got no finish expected finish before 500000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then fill with 0x01..0x40.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 8'(i));

        // 2: write while full is rejected, then drain.
        step(1, 0, 0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);

        // 3: read while empty, then clear the error.
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // 4: stream 100 entries across the pointer wrap with one prefilled.
        step(1, 0, 0, 8'h80);
        for (int i = 0; i < 100; i++) step(1, 1, 0, 8'(8'h81 + i));
        step(0, 1, 0, 8'h00);

        // 5: full with simultaneous write/read, then empty with write/read.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'hC0 ^ i));
        for (int i = 0; i < 10; i++) step(1, 1, 0, 8'(8'h10 + i));
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h5A);
        step(0, 1, 0, 8'h00);

        // 6: asynchronous reset mid-burst at count 37, with data_valid and
        // underflow both set beforehand.
        for (int i = 0; i < 37; i++) step(1, 0, 0, 8'(8'h20 + i));
        step(1, 1, 0, 8'h77);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        err_clr = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        model_q.delete();
        sb_q.delete();
        last_dout = 8'h00;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        #1 reset = 1'b0;
        step(1, 0, 0, 8'hE1);
        step(1, 0, 0, 8'hE2);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);

        // 7: randomized traffic with phases biased toward filling and draining.
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 200; i++) begin
                logic w;
                logic r;
                logic c;
                w = ($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 30));
                r = ($urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 75));
                c = ($urandom_range(0, 99) < 5);
                step(w, r, c, 8'($urandom));
            end
        end

        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
